// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin fetch/data arbiter for a shared block_memory with sub-word read-modify-write
module memory_arbiter #(
  parameter int ADDRESS_SIZE = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fetch_request,
  input  logic [31:0]             fetch_address,
  output logic                    fetch_ready,
  output logic                    fetch_valid,
  output logic [31:0]             fetch_data,
  input  logic                    data_request,
  input  logic                    data_write,
  input  logic [31:0]             data_address,
  input  logic [3:0]              data_byte_mask,
  input  logic [31:0]             data_write_value,
  output logic                    data_ready,
  output logic                    data_valid,
  output logic [31:0]             data_read_value,
  output logic                    mem_read_enable,
  output logic                    mem_write_enable,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  output logic [31:0]             mem_write_data,
  input  logic [31:0]             mem_read_data
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    RMW_WRITE = 2'd2,
    RESPOND   = 2'd3
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  state_t                  state;
  state_t                  next_state;

  // Transaction captured at acceptance
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [3:0]              mask_q;
  logic [31:0]             wdata_q;
  logic                    write_q;
  logic                    port_q;
  logic                    last_grant;
  logic [31:0]             merged_q;

  logic [ADDRESS_SIZE-1:0] fetch_word;
  logic [ADDRESS_SIZE-1:0] data_word;
  logic                    accepting;
  logic                    fetch_wins;
  logic                    grant_fetch;
  logic                    grant_data;
  logic                    full_store;
  logic                    empty_store;
  logic [31:0]             merged_word;
  logic                    unused_address_bits;

  // Byte offset and bits above the memory depth are dropped, so addresses wrap
  assign fetch_word = fetch_address[ADDRESS_SIZE+1:2];
  assign data_word  = data_address[ADDRESS_SIZE+1:2];
  assign unused_address_bits = ^{fetch_address[31:ADDRESS_SIZE+2], fetch_address[1:0],
                                 data_address[31:ADDRESS_SIZE+2], data_address[1:0]};

  // RESPOND is the idle state that also presents last transaction's valid,
  // so a new request can be accepted in the same cycle the response goes out.
  assign accepting   = (state == IDLE) || (state == RESPOND);
  assign fetch_wins  = fetch_request && (!data_request || (last_grant == PORT_DATA));
  assign grant_fetch = accepting && !reset && fetch_wins;
  assign grant_data  = accepting && !reset && data_request && !fetch_wins;
  assign full_store  = (data_byte_mask == 4'b1111);
  assign empty_store = (data_byte_mask == 4'b0000);

  assign fetch_ready = grant_fetch;
  assign data_ready  = grant_data;
  assign fetch_valid = !reset && (state == RESPOND) && (port_q == PORT_FETCH);
  assign data_valid  = !reset && (state == RESPOND) && (port_q == PORT_DATA);

  // Byte-lane merge of the old memory word with the captured store data
  always_comb begin
    merged_word = mem_read_data;
    for (int i = 0; i < 4; i++) begin
      if (mask_q[i]) begin
        merged_word[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end
  end

  // Next state and memory strobes; reset forces every strobe and bus to zero
  always_comb begin
    next_state       = state;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = addr_q;
    mem_write_data   = 32'h0;
    case (state)
      IDLE, RESPOND: begin
        next_state = IDLE;
        if (grant_fetch) begin
          mem_read_enable = 1'b1;
          mem_address     = fetch_word;
          next_state      = READ_WAIT;
        end else if (grant_data) begin
          mem_address = data_word;
          if (!data_write) begin
            mem_read_enable = 1'b1;
            next_state      = READ_WAIT;
          end else if (full_store) begin
            mem_write_enable = 1'b1;
            mem_write_data   = data_write_value;
            next_state       = RESPOND;
          end else if (empty_store) begin
            next_state = RESPOND;
          end else begin
            mem_read_enable = 1'b1;
            next_state      = READ_WAIT;
          end
        end
      end
      READ_WAIT: begin
        next_state = ((port_q == PORT_DATA) && write_q) ? RMW_WRITE : RESPOND;
      end
      RMW_WRITE: begin
        mem_write_enable = 1'b1;
        mem_write_data   = merged_q;
        next_state       = RESPOND;
      end
      default: next_state = IDLE;
    endcase
    if (reset) begin
      next_state       = IDLE;
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
      mem_address      = '0;
      mem_write_data   = 32'h0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture the granted request and advance the round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      mask_q     <= 4'h0;
      wdata_q    <= 32'h0;
      write_q    <= 1'b0;
      port_q     <= PORT_FETCH;
      last_grant <= PORT_DATA;
    end else if (grant_fetch) begin
      addr_q     <= fetch_word;
      write_q    <= 1'b0;
      port_q     <= PORT_FETCH;
      last_grant <= PORT_FETCH;
    end else if (grant_data) begin
      addr_q     <= data_word;
      mask_q     <= data_byte_mask;
      wdata_q    <= data_write_value;
      write_q    <= data_write;
      port_q     <= PORT_DATA;
      last_grant <= PORT_DATA;
    end
  end

  // Read results and RMW merge are taken from memory one cycle after the read
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_data      <= 32'h0;
      data_read_value <= 32'h0;
      merged_q        <= 32'h0;
    end else if (state == READ_WAIT) begin
      if (port_q == PORT_FETCH) begin
        fetch_data <= mem_read_data;
      end else if (!write_q) begin
        data_read_value <= mem_read_data;
      end else begin
        merged_q <= merged_word;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - scoreboard bench for memory_arbiter
module tb_memory_arbiter;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_request;
  logic [31:0]   fetch_address;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [31:0]   fetch_data;
  logic          data_request;
  logic          data_write;
  logic [31:0]   data_address;
  logic [3:0]    data_byte_mask;
  logic [31:0]   data_write_value;
  logic          data_ready;
  logic          data_valid;
  logic [31:0]   data_read_value;
  logic          mem_read_enable;
  logic          mem_write_enable;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic          poke_en;
  logic [AW-1:0] poke_addr;
  logic [31:0]   poke_data;

  typedef struct packed {
    logic        is_store;
    logic [31:0] value;
  } exp_t;

  logic [31:0] fetch_q[$];
  exp_t        data_q[$];
  int          errors = 0;
  int          checks = 0;

  memory_arbiter #(.ADDRESS_SIZE(AW)) dut (
    .clk(clk), .reset(reset),
    .fetch_request(fetch_request), .fetch_address(fetch_address),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .data_request(data_request), .data_write(data_write), .data_address(data_address),
    .data_byte_mask(data_byte_mask), .data_write_value(data_write_value),
    .data_ready(data_ready), .data_valid(data_valid), .data_read_value(data_read_value),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Block memory model with 1-cycle registered read, plus a preload port
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address] <= mem_write_data;
    if (poke_en) mem[poke_addr] <= poke_data;
    if (mem_read_enable) mem_read_data <= mem[mem_address];
  end

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [31:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    advance();
    poke_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_request = 1'b1; data_request = 1'b1; data_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({fetch_ready, data_ready, fetch_valid, data_valid, mem_read_enable, mem_write_enable} !== 6'b0) begin
        errors++;
        $display("FAIL reset_strobes: got %b want 000000", {fetch_ready, data_ready, fetch_valid, data_valid, mem_read_enable, mem_write_enable});
      end
      checks++;
      if ({fetch_data, data_read_value, mem_write_data} !== 96'h0 || mem_address !== '0) begin
        errors++;
        $display("FAIL reset_buses: got fd=%h dr=%h wd=%h ad=%h want all zero", fetch_data, data_read_value, mem_write_data, mem_address);
      end
      advance();
    end
    fetch_request = 1'b0; data_request = 1'b0; reset = 1'b0;
  endtask

  task automatic test_fetch();
    logic [31:0] e;
    poke(5, 32'h00500093);
    fetch_request = 1'b1; fetch_address = 32'h14;
    @(negedge clk);
    checks++;
    if (fetch_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready: got %b want 1", fetch_ready); end
    checks++;
    if (mem_read_enable !== 1'b1 || mem_write_enable !== 1'b0) begin
      errors++; $display("FAIL fetch_read_strobe: got re=%b we=%b want re=1 we=0", mem_read_enable, mem_write_enable);
    end
    checks++;
    if (mem_address !== 12'd5) begin errors++; $display("FAIL fetch_address: got %0d want 5", mem_address); end
    fetch_q.push_back(32'h00500093);
    advance();
    fetch_request = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid_early: got %b want 0", fetch_valid); end
    advance();
    @(negedge clk);
    checks++;
    if (fetch_valid !== 1'b1) begin
      errors++; $display("FAIL fetch_valid_t2: got %b want 1", fetch_valid);
    end else begin
      e = fetch_q.pop_front();
      checks++;
      if (fetch_data !== e) begin errors++; $display("FAIL fetch_data: got %h want %h", fetch_data, e); end
    end
    advance();
  endtask

  task automatic test_contention();
    logic [31:0] ef;
    exp_t        ed;
    logic        exp_f;
    logic        exp_d;
    reset = 1'b1;
    advance();
    reset = 1'b0;
    poke(12'd64, 32'h11110100);
    poke(12'd128, 32'h22220200);
    fetch_request = 1'b1; fetch_address = 32'h100;
    data_request = 1'b1; data_write = 1'b0; data_address = 32'h200;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_f = (i < 8) && (i % 4 == 0);
      exp_d = (i < 8) && (i % 4 == 2);
      checks++;
      if ({fetch_ready, data_ready} !== {exp_f, exp_d}) begin
        errors++; $display("FAIL contention_grant cycle %0d: got f=%b d=%b want f=%b d=%b", i, fetch_ready, data_ready, exp_f, exp_d);
      end
      checks++;
      if (mem_read_enable && mem_write_enable) begin
        errors++; $display("FAIL contention_exclusive cycle %0d: got re=1 we=1 want at most one", i);
      end
      if (exp_f) fetch_q.push_back(32'h11110100);
      if (exp_d) data_q.push_back('{1'b0, 32'h22220200});
      if (fetch_valid) begin
        checks++;
        if (fetch_q.size() == 0) begin
          errors++; $display("FAIL contention_fetch_unexpected cycle %0d: got valid want none", i);
        end else begin
          ef = fetch_q.pop_front();
          if (fetch_data !== ef) begin errors++; $display("FAIL contention_fetch_data: got %h want %h", fetch_data, ef); end
        end
      end
      if (data_valid) begin
        checks++;
        if (data_q.size() == 0) begin
          errors++; $display("FAIL contention_data_unexpected cycle %0d: got valid want none", i);
        end else begin
          ed = data_q.pop_front();
          if (ed.is_store || data_read_value !== ed.value) begin
            errors++; $display("FAIL contention_data_value: got %h want %h", data_read_value, ed.value);
          end
        end
      end
      advance();
      if (i == 7) begin fetch_request = 1'b0; data_request = 1'b0; end
    end
  endtask

  task automatic test_byte_store();
    exp_t ed;
    poke(12'd8, 32'hAABBCCDD);
    data_request = 1'b1; data_write = 1'b1; data_address = 32'h21;
    data_byte_mask = 4'b0010; data_write_value = 32'h00001100;
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b1 || mem_read_enable !== 1'b1 || mem_write_enable !== 1'b0 || mem_address !== 12'd8) begin
      errors++; $display("FAIL rmw_t0: got rdy=%b re=%b we=%b ad=%0d want 1 1 0 8", data_ready, mem_read_enable, mem_write_enable, mem_address);
    end
    data_q.push_back('{1'b1, 32'h0});
    advance();
    data_request = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0 || data_valid !== 1'b0) begin
      errors++; $display("FAIL rmw_t1: got re=%b we=%b dv=%b want 0 0 0", mem_read_enable, mem_write_enable, data_valid);
    end
    advance();
    @(negedge clk);
    checks++;
    if (mem_write_enable !== 1'b1 || mem_read_enable !== 1'b0 || mem_address !== 12'd8 || data_valid !== 1'b0) begin
      errors++; $display("FAIL rmw_t2_strobe: got we=%b re=%b ad=%0d dv=%b want 1 0 8 0", mem_write_enable, mem_read_enable, mem_address, data_valid);
    end
    checks++;
    if (mem_write_data !== 32'hAABB11DD) begin errors++; $display("FAIL rmw_merge: got %h want aabb11dd", mem_write_data); end
    advance();
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b1) begin
      errors++; $display("FAIL rmw_valid_t3: got %b want 1", data_valid);
    end else begin
      ed = data_q.pop_front();
      checks++;
      if (!ed.is_store) begin errors++; $display("FAIL rmw_scoreboard: got load entry want store entry"); end
    end
    advance();
    data_request = 1'b1; data_write = 1'b0; data_address = 32'h20;
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b1) begin errors++; $display("FAIL rmw_reload_ready: got %b want 1", data_ready); end
    data_q.push_back('{1'b0, 32'hAABB11DD});
    advance();
    data_request = 1'b0;
    advance();
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b1) begin
      errors++; $display("FAIL rmw_reload_valid: got %b want 1", data_valid);
    end else begin
      ed = data_q.pop_front();
      checks++;
      if (data_read_value !== ed.value) begin errors++; $display("FAIL rmw_reload_data: got %h want %h", data_read_value, ed.value); end
    end
    advance();
  endtask

  task automatic test_full_store();
    exp_t ed;
    data_request = 1'b1; data_write = 1'b1; data_address = 32'h40;
    data_byte_mask = 4'b1111; data_write_value = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b1 || mem_write_enable !== 1'b1 || mem_read_enable !== 1'b0 || mem_address !== 12'd16) begin
      errors++; $display("FAIL full_t0: got rdy=%b we=%b re=%b ad=%0d want 1 1 0 16", data_ready, mem_write_enable, mem_read_enable, mem_address);
    end
    checks++;
    if (mem_write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL full_wdata: got %h want deadbeef", mem_write_data); end
    data_q.push_back('{1'b1, 32'h0});
    advance();
    data_request = 1'b0;
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b1 || mem_write_enable !== 1'b0 || mem_read_enable !== 1'b0) begin
      errors++; $display("FAIL full_t1: got dv=%b we=%b re=%b want 1 0 0", data_valid, mem_write_enable, mem_read_enable);
    end else begin
      ed = data_q.pop_front();
    end
    checks++;
    if (mem[16] !== 32'hDEADBEEF) begin errors++; $display("FAIL full_mem: got %h want deadbeef", mem[16]); end
    advance();
  endtask

  task automatic test_mask_zero();
    exp_t ed;
    poke(12'd20, 32'h5A5A5A5A);
    data_request = 1'b1; data_write = 1'b1; data_address = 32'h50;
    data_byte_mask = 4'b0000; data_write_value = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b1 || mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin
      errors++; $display("FAIL mask0_t0: got rdy=%b re=%b we=%b want 1 0 0", data_ready, mem_read_enable, mem_write_enable);
    end
    data_q.push_back('{1'b1, 32'h0});
    advance();
    data_request = 1'b0;
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b1 || mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin
      errors++; $display("FAIL mask0_t1: got dv=%b re=%b we=%b want 1 0 0", data_valid, mem_read_enable, mem_write_enable);
    end else begin
      ed = data_q.pop_front();
    end
    advance();
    checks++;
    if (mem[20] !== 32'h5A5A5A5A) begin errors++; $display("FAIL mask0_mem: got %h want 5a5a5a5a", mem[20]); end
  endtask

  task automatic test_reset_mid_rmw();
    poke(12'd12, 32'h12345678);
    data_request = 1'b1; data_write = 1'b1; data_address = 32'h30;
    data_byte_mask = 4'b0001; data_write_value = 32'h000000FF;
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b1 || mem_read_enable !== 1'b1) begin
      errors++; $display("FAIL midrst_accept: got rdy=%b re=%b want 1 1", data_ready, mem_read_enable);
    end
    advance();
    data_request = 1'b0; reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({fetch_ready, data_ready, fetch_valid, data_valid, mem_read_enable, mem_write_enable} !== 6'b0 || mem_address !== '0) begin
        errors++; $display("FAIL midrst_during cycle %0d: got %b ad=%0d want 000000 ad=0", i,
          {fetch_ready, data_ready, fetch_valid, data_valid, mem_read_enable, mem_write_enable}, mem_address);
      end
      advance();
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_write_enable !== 1'b0 || data_valid !== 1'b0) begin
        errors++; $display("FAIL midrst_after cycle %0d: got we=%b dv=%b want 0 0", i, mem_write_enable, data_valid);
      end
      advance();
    end
    checks++;
    if (mem[12] !== 32'h12345678) begin errors++; $display("FAIL midrst_mem: got %h want 12345678", mem[12]); end
  endtask

  initial begin
    reset = 1'b1; fetch_request = 1'b0; fetch_address = 32'h0;
    data_request = 1'b0; data_write = 1'b0; data_address = 32'h0;
    data_byte_mask = 4'h0; data_write_value = 32'h0;
    poke_en = 1'b0; poke_addr = '0; poke_data = 32'h0;
    test_reset();
    test_fetch();
    test_contention();
    test_byte_store();
    test_full_store();
    test_mask_zero();
    test_reset_mid_rmw();
    checks++;
    if (fetch_q.size() != 0 || data_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got fetch=%0d data=%0d pending want 0 0", fetch_q.size(), data_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
